// File: rtl/debouncer.sv
// debouncer: turns a raw, bouncing button/switch level into one clean level.
// An optional two-flop synchronizer feeds a stability counter and a 4-state
// Moore FSM. The output follows the input only after it has held a new value
// for DEBOUNCE_CLKS consecutive cycles. Any reversal during that window
// returns the FSM to the previous stable state and discards the partial count.
//
// Build option: define DEBOUNCER_SYNC_EN to insert the 2-flop synchronizer.
// Use it for truly asynchronous pins; it adds 2 cycles of latency. Without
// the macro, noisy is sampled by the FSM directly.
//
// Ports:
//   clk        in   global clock, all state on posedge
//   rst        in   synchronous active-high reset
//   noisy      in   raw button/switch input
//   debounced  out  stable, glitch-free level (registered)
module debouncer #(
  parameter int unsigned DEBOUNCE_CLKS = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic noisy,
  output logic debounced
);

  localparam int unsigned CNT_WIDTH = $clog2(DEBOUNCE_CLKS) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CLKS - 1);

  localparam logic [1:0] S0    = 2'b00;
  localparam logic [1:0] WAIT1 = 2'b01;
  localparam logic [1:0] S1    = 2'b10;
  localparam logic [1:0] WAIT0 = 2'b11;

  logic                 sync_in;
  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 debounced_q, debounced_d;

`ifdef DEBOUNCER_SYNC_EN
  // Two-flop synchronizer for an asynchronous pin
  logic sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= noisy;
      sync2_q <= sync1_q;
    end
  end

  assign sync_in = sync2_q;
`else
  assign sync_in = noisy;
`endif

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S0;
      cnt_q       <= '0;
      debounced_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      debounced_q <= debounced_d;
    end
  end

  // Next-state and counter logic; a reversal in a WAIT state wins over expiry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S0: begin
        if (sync_in) begin
          state_d = WAIT1;
          cnt_d   = '0;
        end
      end
      WAIT1: begin
        if (!sync_in) begin
          state_d = S0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      S1: begin
        if (!sync_in) begin
          state_d = WAIT0;
          cnt_d   = '0;
        end
      end
      WAIT0: begin
        if (sync_in) begin
          state_d = S1;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = S0;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore output decoded from the next state so it registers with the state
  always_comb begin
    debounced_d = (state_d == S1) || (state_d == WAIT0);
  end

  assign debounced = debounced_q;

endmodule
